ssd_min_select: RTL and testbench

//  Winner-take-all stage downstream of the PE output delay line.
//  - Consumes the aligned SSD stream: one SSD per candidate disparity, d = 0..DISP_NUM-1, in order.
//  - Tracks the running minimum over the DISP_NUM candidates of each pixel.
//  - Emits the winning disparity index and its SSD as a single-cycle valid pulse per pixel.

---
 rtl/ssd_pkg.sv | 12 +
 rtl/ssd_cmp_upd.sv | 46 ++++
 rtl/ssd_min_select.sv | 134 +++++++++++++
 tb/tb_ssd_min_select.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and defaults for the SSD winner-take-all stage.
// Build option: SSD_UNIQ_CHK_EN enables second-best tracking and the uniqueness test.
package ssd_pkg;

    localparam int SSD_W_DFLT    = 20;
    localparam int DISP_NUM_DFLT = 64;

    localparam logic [SSD_W_DFLT-1:0] SSD_MAX = {SSD_W_DFLT{1'b1}};

    typedef logic [SSD_W_DFLT-1:0] ssd_t;

endpackage

// File: rtl/ssd_cmp_upd.sv
// Combinational running-minimum update; shared by the running registers and the final compare.
// Build option: SSD_UNIQ_CHK_EN adds the second-best input/output pair.
module ssd_cmp_upd
    import ssd_pkg::*;
#(
    parameter int W  = SSD_W_DFLT,
    parameter int IW = 6
) (
    input  logic [W-1:0]  cur_i,
    input  logic [IW-1:0] idx_i,
    input  logic [W-1:0]  min_i,
    input  logic [IW-1:0] min_idx_i,
`ifdef SSD_UNIQ_CHK_EN
    input  logic [W-1:0]  sec_i,
    output logic [W-1:0]  sec_o,
`endif
    input  logic          first_i,
    output logic [W-1:0]  min_o,
    output logic [IW-1:0] min_idx_o
);

    always_comb begin
        min_o     = min_i;
        min_idx_o = min_idx_i;
`ifdef SSD_UNIQ_CHK_EN
        sec_o     = sec_i;
`endif
        if (first_i) begin
            min_o     = cur_i;
            min_idx_o = '0;
`ifdef SSD_UNIQ_CHK_EN
            sec_o     = '1;
`endif
        end else if (cur_i < min_i) begin
            // strict compare: an equal SSD never displaces the lower index
            min_o     = cur_i;
            min_idx_o = idx_i;
`ifdef SSD_UNIQ_CHK_EN
            sec_o     = min_i;
        end else if (cur_i < sec_i) begin
            sec_o     = cur_i;
`endif
        end
    end

endmodule

// File: rtl/ssd_min_select.sv
// Winner-take-all over DISP_NUM candidate SSDs per pixel; one-cycle result pulse per pixel.
// Build option: SSD_UNIQ_CHK_EN enables the uniqueness margin test on the winner.
module ssd_min_select
    import ssd_pkg::*;
#(
    parameter int              SSD_W    = SSD_W_DFLT,
    parameter int              DISP_NUM = DISP_NUM_DFLT,
    localparam int             DISP_W   = (DISP_NUM > 1) ? $clog2(DISP_NUM) : 1,
    parameter logic [SSD_W-1:0] UNIQ_THR = SSD_W'(256)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_clr,
    input  logic [SSD_W-1:0]  ssd_i,
    input  logic              ssd_ivalid,
    output logic [DISP_W-1:0] disp_o,
    output logic [SSD_W-1:0]  min_ssd_o,
    output logic              disp_unique,
    output logic              disp_ovalid
);

    localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(DISP_NUM - 1);

    logic [DISP_W-1:0] cand_cnt_q, cand_cnt_d, cnt_eff;
    logic [SSD_W-1:0]  run_min_q, run_min_d;
    logic [DISP_W-1:0] run_idx_q, run_idx_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic [SSD_W-1:0]  min_ssd_q, min_ssd_d;
    logic              uniq_q, uniq_d;
    logic              ovalid_q, ovalid_d;

    logic [SSD_W-1:0]  nxt_min;
    logic [DISP_W-1:0] nxt_idx;
    logic              first, last;

`ifdef SSD_UNIQ_CHK_EN
    logic [SSD_W-1:0]  run_2nd_q, run_2nd_d;
    logic [SSD_W-1:0]  nxt_2nd;
    logic [SSD_W-1:0]  margin;
`endif

    // sync_clr makes this cycle's sample candidate 0 regardless of the count
    assign cnt_eff = sync_clr ? '0 : cand_cnt_q;
    assign first   = (cnt_eff == '0);
    assign last    = (cnt_eff == LAST_IDX);

    ssd_cmp_upd #(
        .W  (SSD_W),
        .IW (DISP_W)
    ) u_cmp (
        .cur_i     (ssd_i),
        .idx_i     (cnt_eff),
        .min_i     (run_min_q),
        .min_idx_i (run_idx_q),
`ifdef SSD_UNIQ_CHK_EN
        .sec_i     (run_2nd_q),
        .sec_o     (nxt_2nd),
`endif
        .first_i   (first),
        .min_o     (nxt_min),
        .min_idx_o (nxt_idx)
    );

`ifdef SSD_UNIQ_CHK_EN
    assign margin = nxt_2nd - nxt_min;
`endif

    always_comb begin
        cand_cnt_d = cnt_eff;
        run_min_d  = run_min_q;
        run_idx_d  = run_idx_q;
        disp_d     = disp_q;
        min_ssd_d  = min_ssd_q;
        ovalid_d   = 1'b0;
`ifdef SSD_UNIQ_CHK_EN
        run_2nd_d  = run_2nd_q;
        uniq_d     = uniq_q;
`else
        uniq_d     = 1'b1;
`endif
        if (ssd_ivalid) begin
            run_min_d  = nxt_min;
            run_idx_d  = nxt_idx;
`ifdef SSD_UNIQ_CHK_EN
            run_2nd_d  = nxt_2nd;
`endif
            cand_cnt_d = last ? '0 : cnt_eff + 1'b1;
            if (last) begin
                disp_d    = nxt_idx;
                min_ssd_d = nxt_min;
                ovalid_d  = 1'b1;
`ifdef SSD_UNIQ_CHK_EN
                uniq_d    = (margin > UNIQ_THR);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_cnt_q <= '0;
            run_min_q  <= '0;
            run_idx_q  <= '0;
            disp_q     <= '0;
            min_ssd_q  <= '0;
            uniq_q     <= 1'b0;
            ovalid_q   <= 1'b0;
        end else begin
            cand_cnt_q <= cand_cnt_d;
            run_min_q  <= run_min_d;
            run_idx_q  <= run_idx_d;
            disp_q     <= disp_d;
            min_ssd_q  <= min_ssd_d;
            uniq_q     <= uniq_d;
            ovalid_q   <= ovalid_d;
        end
    end

`ifdef SSD_UNIQ_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_2nd_q <= '1;
        end else begin
            run_2nd_q <= run_2nd_d;
        end
    end
`endif

    assign disp_o      = disp_q;
    assign min_ssd_o   = min_ssd_q;
    assign disp_unique = uniq_q;
    assign disp_ovalid = ovalid_q;

endmodule

// File: tb/tb_ssd_min_select.sv
// Scoreboard bench for ssd_min_select (DISP_NUM=4, UNIQ_THR=10); honours SSD_UNIQ_CHK_EN.
module tb_ssd_min_select;

    localparam int SW  = 20;
    localparam int DN  = 4;
    localparam int DW  = 2;
    localparam int THR = 10;

`ifdef SSD_UNIQ_CHK_EN
    localparam logic UNIQ_IDLE = 1'b0;
`else
    localparam logic UNIQ_IDLE = 1'b1;
`endif

    typedef struct {
        int            cyc;
        logic [DW-1:0] disp;
        logic [SW-1:0] mn;
        logic          uniq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync_clr = 1'b0;
    logic [SW-1:0] ssd_i = '0;
    logic          ssd_ivalid = 1'b0;
    logic [DW-1:0] disp_o;
    logic [SW-1:0] min_ssd_o;
    logic          disp_unique;
    logic          disp_ovalid;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic          rst_at_edge = 1'b0;
    exp_t          exp_q[$];
    logic [SW-1:0] pix[$];

    ssd_min_select #(
        .SSD_W    (SW),
        .DISP_NUM (DN),
        .UNIQ_THR (SW'(THR))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_clr    (sync_clr),
        .ssd_i       (ssd_i),
        .ssd_ivalid  (ssd_ivalid),
        .disp_o      (disp_o),
        .min_ssd_o   (min_ssd_o),
        .disp_unique (disp_unique),
        .disp_ovalid (disp_ovalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_at_edge = rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: winner is the first occurrence of the smallest value, runner-up is the
    // second element of the sorted multiset.
    function automatic exp_t model(input logic [SW-1:0] s[$]);
        exp_t          e;
        logic [SW-1:0] srt[$];
        logic [SW-1:0] sec;
        e.disp = '0;
        e.mn   = s[0];
        for (int i = 1; i < s.size(); i++)
            if (s[i] < e.mn) begin
                e.mn   = s[i];
                e.disp = DW'(i);
            end
        srt = s;
        srt.sort();
        sec = (srt.size() > 1) ? srt[1] : '1;
`ifdef SSD_UNIQ_CHK_EN
        e.uniq = ((sec - e.mn) > SW'(THR));
`else
        e.uniq = (sec == sec);
`endif
        e.cyc = 0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic clr);
        exp_t e;
        @(posedge clk);
        #1;
        ssd_ivalid = v;
        ssd_i      = s;
        sync_clr   = clr;
        if (clr) pix.delete();
        if (v) begin
            pix.push_back(s);
            if (pix.size() == DN) begin
                e     = model(pix);
                e.cyc = cyc + 1;
                exp_q.push_back(e);
                pix.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, SW'($urandom), 1'b0);
    endtask

    task automatic send4(input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input logic [SW-1:0] c, input logic [SW-1:0] d, input int maxgap);
        logic [SW-1:0] v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v[i], 1'b0);
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    // Monitor: pops on every pulse, otherwise checks that the last result is held.
    logic [DW-1:0] hd;
    logic [SW-1:0] hm;
    logic          hu;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !rst_at_edge) begin
            check("rst_ovalid", 32'(disp_ovalid), 0);
            check("rst_disp", 32'(disp_o), 0);
            check("rst_min", 32'(min_ssd_o), 0);
            check("rst_uniq", 32'(disp_unique), 0);
            hd = '0;
            hm = '0;
            hu = UNIQ_IDLE;
        end else if (disp_ovalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(disp_ovalid), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("disp_o", 32'(disp_o), 32'(e.disp));
                check("min_ssd_o", 32'(min_ssd_o), 32'(e.mn));
                check("disp_unique", 32'(disp_unique), 32'(e.uniq));
                hd = e.disp;
                hm = e.mn;
                hu = e.uniq;
            end
        end else begin
            check("hold_disp", 32'(disp_o), 32'(hd));
            check("hold_min", 32'(min_ssd_o), 32'(hm));
            check("hold_uniq", 32'(disp_unique), 32'(hu));
        end
    end

    initial begin
        idle(3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        send4(50, 20, 30, 40, 0);
        idle(2);
        send4(7, 7, 9, 7, 0);
        idle(2);
        send4(100, 40, 90, 45, 3);
        idle(2);
        send4(9, 8, 7, 6, 0);
        send4(1, 2, 3, 4, 0);
        idle(3);

        drive(1'b1, 5, 1'b0);
        drive(1'b1, 3, 1'b0);
        drive(1'b1, 60, 1'b1);
        drive(1'b1, 70, 1'b0);
        drive(1'b1, 2, 1'b0);
        drive(1'b1, 80, 1'b0);
        idle(3);

        drive(1'b1, 11, 1'b0);
        drive(1'b1, 12, 1'b0);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        ssd_ivalid = 1'b0;
        sync_clr   = 1'b0;
        pix.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send4(20'h3, 20'h1, 20'hFFFFF, 20'h2, 0);
        idle(2);
        send4(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 0);
        send4(20'h10, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 0);
        idle(2);

        for (int i = 0; i < 200; i++) begin
            logic [SW-1:0] s;
            s = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, 40));
            drive(1'b1, s, ($urandom_range(0, 24) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(6);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
